// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and constants
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // Baud divisors for a 50 MHz system clock
    localparam int DIV_4800  = 651;
    localparam int DIV_9600  = 326;
    localparam int DIV_19200 = 163;
    localparam int DIV_38400 = 81;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - show-ahead receive FIFO; a push into a full FIFO succeeds only alongside a pop
module rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 w_pop;
    logic                 w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == DEPTH);
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - 8N1 serial receiver with 16x oversampling, receive FIFO and sticky error flags
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rxd,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 r_rxd_meta;
    logic                 r_rxd_s;
    logic                 r_rxd_prev;
    logic [1:0]           r_settle;
    logic                 r_armed;
    rx_state_t            r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_busy;
    logic                 r_framing_err;
    logic                 r_overrun_err;

    logic                 w_fall;
    logic                 w_stop_tick;
    logic                 w_push;
    logic                 w_overrun;
    logic                 w_frame_bad;
    logic                 w_empty;
    logic                 w_full;

    // Edges only count once the line has been seen high after reset, so a
    // line held low through reset cannot fake a start bit.
    assign w_fall      = r_armed & r_rxd_prev & ~r_rxd_s;
    assign w_stop_tick = (r_state == STOP) & baud_tick & (r_tick_cnt == FULL_M1);
    assign w_push      = w_stop_tick & r_rxd_s;
    assign w_overrun   = w_push & w_full & ~rd_en;
    assign w_frame_bad = w_stop_tick & ~r_rxd_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_settle   <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rxd_prev <= r_rxd_s;
            r_settle   <= {r_settle[0], 1'b1};
            r_armed    <= r_armed | (r_settle[1] & r_rxd_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == HALF_M1) begin
                            r_tick_cnt <= '0;
                            if (!r_rxd_s) begin
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_shift    <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + BW'(1);
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_state    <= IDLE;
                            r_tick_cnt <= '0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A new error wins over a clear arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_frame_bad) begin
                r_framing_err <= 1'b1;
            end else if (err_clr) begin
                r_framing_err <= 1'b0;
            end
            if (w_overrun) begin
                r_overrun_err <= 1'b1;
            end else if (err_clr) begin
                r_overrun_err <= 1'b0;
            end
        end
    end

    rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (rd_en),
        .din   (r_shift),
        .dout  (rx_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign rx_valid    = ~w_empty;
    assign rx_busy     = r_busy;
    assign framing_err = r_framing_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - scoreboard bench for spart_rx
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic       rxd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_err;
    logic       overrun_err;

    logic       rd_stim;
    logic       clr_stim;
    logic       rd_auto;
    logic       clr_auto;
    int         arm_id;
    logic       arm_clr;
    int         fired;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];

    assign rd_en   = rd_stim | rd_auto;
    assign err_clr = clr_stim | clr_auto;

    spart_rx u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Baud tick every 4 cycles; optionally pulse rd_en or err_clr on the
    // 152nd tick of a frame (8 start + 8*16 data + 16 stop = stop sample).
    initial begin
        int tdiv;
        int gen_id;
        int tcnt;
        logic active;
        tdiv = 0; gen_id = 0; tcnt = 0; active = 1'b0;
        baud_tick = 1'b0; rd_auto = 1'b0; clr_auto = 1'b0; fired = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (tdiv == 3);
            tdiv      = (tdiv + 1) % 4;
            rd_auto   = 1'b0;
            clr_auto  = 1'b0;
            if (arm_id != gen_id) begin
                gen_id = arm_id;
                tcnt   = 0;
                active = 1'b1;
            end
            if (active && rx_busy && baud_tick) begin
                tcnt++;
                if (tcnt == 152) begin
                    if (arm_clr) clr_auto = 1'b1;
                    else         rd_auto  = 1'b1;
                    fired++;
                    active = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_en && rx_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h expected none", rx_data);
            end else begin
                check("rx_data", {24'h0, rx_data}, {24'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            cyc(64);
        end
        rxd = 1'b1;
        cyc(16);
    endtask

    task automatic pop_one();
        rd_stim = 1'b1;
        cyc(1);
        rd_stim = 1'b0;
        cyc(1);
    endtask

    task automatic clr_pulse();
        clr_stim = 1'b1;
        cyc(1);
        clr_stim = 1'b0;
        cyc(1);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        int n = 0;
        while (rx_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'h0, rx_busy}, {31'h0, lvl});
    endtask

    initial begin
        int bad;
        int f0;
        rst_n = 1'b0; rxd = 1'b1; rd_stim = 1'b0; clr_stim = 1'b0;
        arm_id = 0; arm_clr = 1'b0;
        cyc(3);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_rx_busy", {31'h0, rx_busy}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_errs", {30'h0, framing_err, overrun_err}, 32'h0);
        rst_n = 1'b1;
        cyc(8);

        // 1: clean 0xA5 frame, push visible the cycle busy drops
        sb_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_busy(1'b1, 200, "t1_busy_rise");
                check("t1_valid_before", {31'h0, rx_valid}, 32'h0);
                wait_busy(1'b0, 1000, "t1_busy_fall");
                check("t1_valid_at_stop", {31'h0, rx_valid}, 32'h1);
            end
        join
        check("t1_errs", {30'h0, framing_err, overrun_err}, 32'h0);
        pop_one();
        check("t1_valid_after_pop", {31'h0, rx_valid}, 32'h0);

        // 2: short glitch aborts in START
        rxd = 1'b0;
        cyc(12);
        rxd = 1'b1;
        check("t2_busy_in_start", {31'h0, rx_busy}, 32'h1);
        cyc(100);
        check("t2_busy_after", {31'h0, rx_busy}, 32'h0);
        check("t2_valid", {31'h0, rx_valid}, 32'h0);
        check("t2_errs", {30'h0, framing_err, overrun_err}, 32'h0);

        // 3: framing error, set beats clear
        send_frame(8'h3C, 1'b0);
        check("t3_framing", {31'h0, framing_err}, 32'h1);
        check("t3_valid", {31'h0, rx_valid}, 32'h0);
        f0 = fired;
        arm_clr = 1'b1;
        arm_id++;
        send_frame(8'h3C, 1'b0);
        check("t3_clr_fired", fired, f0 + 1);
        check("t3_framing_kept", {31'h0, framing_err}, 32'h1);
        clr_pulse();
        check("t3_framing_clr", {31'h0, framing_err}, 32'h0);

        // 4: overrun on fifth byte
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) sb_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        check("t4_overrun", {31'h0, overrun_err}, 32'h1);
        check("t4_valid", {31'h0, rx_valid}, 32'h1);
        check("t4_framing", {31'h0, framing_err}, 32'h0);
        repeat (4) pop_one();
        check("t4_valid_empty", {31'h0, rx_valid}, 32'h0);
        pop_one();
        check("t4_valid_underflow", {31'h0, rx_valid}, 32'h0);
        check("t4_sb_drained", sb_q.size(), 0);
        clr_pulse();
        check("t4_overrun_clr", {31'h0, overrun_err}, 32'h0);

        // 5: full FIFO, pop on the stop-sample cycle
        for (int b = 1; b <= 4; b++) begin
            sb_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        sb_q.push_back(8'h05);
        f0 = fired;
        arm_clr = 1'b0;
        arm_id++;
        send_frame(8'h05, 1'b1);
        check("t5_rd_fired", fired, f0 + 1);
        check("t5_overrun", {31'h0, overrun_err}, 32'h0);
        check("t5_valid", {31'h0, rx_valid}, 32'h1);
        repeat (4) pop_one();
        check("t5_valid_empty", {31'h0, rx_valid}, 32'h0);
        check("t5_sb_drained", sb_q.size(), 0);

        // 6: reset during data bit 3 with two bytes queued
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        sb_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        check("t6_valid_pre", {31'h0, rx_valid}, 32'h1);
        rxd = 1'b0;
        cyc(64 * 4 + 32);
        check("t6_busy_mid", {31'h0, rx_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("t6_rst_outs", {21'h0, rx_data, rx_valid, rx_busy, framing_err, overrun_err}, 32'h0);
        cyc(5);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (rx_busy !== 1'b0) bad++;
        end
        check("t6_no_start_low", bad, 0);
        check("t6_valid_low", {31'h0, rx_valid}, 32'h0);
        rxd = 1'b1;
        cyc(64);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        check("t6_valid_new", {31'h0, rx_valid}, 32'h1);
        check("t6_errs", {30'h0, framing_err, overrun_err}, 32'h0);
        pop_one();
        check("t6_valid_end", {31'h0, rx_valid}, 32'h0);
        check("t6_sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Serial receiver for the SPART: consumes the 16x oversampling enable from the baud generator and deserialises 8N1 frames from the `rxd` line.
- Received bytes go into a small show-ahead receive FIFO that the bus interface reads.
- Reports framing and overrun errors as sticky flags.
- Sits between the baud generator and the processor-facing register interface.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even.
- FIFO_DEPTH, 4, receive FIFO entries; power of two.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_tick  in  1  one-cycle oversample enable from the baud generator.
- rxd  in  1  asynchronous serial line; idles high.
- rd_en  in  1  pop the FIFO head.
- err_clr  in  1  clear both error flags.
- rx_data  out  DATA_BITS  FIFO head byte; valid while rx_valid=1.
- rx_valid  out  1  FIFO not empty (receive data available).
- rx_busy  out  1  FSM is not in IDLE.
- framing_err  out  1  sticky; stop bit sampled low.
- overrun_err  out  1  sticky; byte dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0) forces:
  - 2-flop rxd synchroniser and edge register to 1.
  - FSM to IDLE; tick_cnt=0, bit_cnt=0, shift register=0.
  - FIFO empty.
  - All outputs 0: rx_data=0, rx_valid=0, rx_busy=0, framing_err=0, overrun_err=0.
- Reset mid-frame discards the partial frame and all FIFO contents.
- rxd_s = synchronised rxd (2 flops). Falling edge = previous rxd_s 1, current rxd_s 0.
- IDLE:
  - On a falling edge, go to START and clear tick_cnt. This happens independently of baud_tick.
  - A low line after reset or after a break starts nothing until the line goes high and falls again.
- START: advance only on baud_tick (tick_cnt++). On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rxd_s=0: go to DATA; tick_cnt=0, bit_cnt=0.
  - rxd_s=1: false start; return to IDLE, no flags set.
- DATA: on each baud_tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE-1:
  - Shift rxd_s into the MSB of the shift register (shift right); tick_cnt=0; bit_cnt++.
  - After DATA_BITS samples go to STOP. The register then holds the byte LSB-correct.
- STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rxd_s and go to IDLE:
  - 1 and FIFO not full: push the byte.
  - 1 and FIFO full: drop the byte, set overrun_err. FIFO is unchanged.
  - 0: drop the byte, set framing_err. No push.
- No baud_tick means the FSM holds state and all counters.
- Push latency: rx_valid rises the cycle after the stop-sample tick.
- FIFO is show-ahead:
  - rx_data reflects the head combinationally from storage.
  - rd_en with rx_valid=1 pops on that clock edge.
  - rd_en when empty is ignored; no underflow and no pointer movement.
- Push and pop in the same cycle:
  - When full, both succeed; no overrun, count unchanged.
  - When empty, only the push takes effect; the pop is ignored.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Error flags:
  - Set has priority over err_clr in the same cycle.
  - Flags never clear themselves.
  - The FSM keeps running regardless of flag state.
- rx_busy = (state != IDLE), registered from the state.

Decomposition:
- Package spart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Constants for the default OVERSAMPLE and DATA_BITS.
  - Shared divisor constants for 4800/9600/19200/38400 at 50 MHz: 651, 326, 163, 81.
- Sub-module rx_fifo: synchronous FIFO with parameters DATA_BITS and FIFO_DEPTH, and ports push, pop, din, dout, empty, full. Verified standalone.
- spart_rx holds the synchroniser, the FSM, the counters and the error flags.

Test Plan:
1. Frame 0xA5 with a 4-cycle baud_tick period (bit = 64 cycles), start + 10100101 LSB first + stop 1 → rx_valid=1 one cycle after the stop tick; rx_data=0xA5; no errors; rx_busy=0.
2. Low pulse of 3 ticks (~12 cycles) from idle → START aborts at the 8th tick, back to IDLE; rx_valid=0; no errors.
3. Frame 0x3C with the stop bit driven 0 → framing_err=1, rx_valid=0. Assert err_clr in the same cycle as a second bad stop → framing_err stays 1. err_clr alone → 0.
4. Send 5 bytes 0x01..0x05 without reads (FIFO_DEPTH=4) → FIFO holds 0x01..0x04 and overrun_err=1. Pops return 0x01..0x04, then rx_valid=0. A 5th rd_en is ignored.
5. With the FIFO full, assert rd_en on the cycle of the 5th byte's stop sample → no overrun; FIFO reads 0x02..0x05.
6. Assert rst_n=0 during data bit 3 with the FIFO holding 2 bytes → all outputs 0 immediately. With rxd held low through and after reset, no frame starts. After rxd goes high, a new 0x5A frame is received correctly.
